aes_round_ctrl: RTL
===================

Name: aes_round_ctrl

Overview:
- Sequencer for the AES-128 4x4 byte state matrix (4 x 32-bit word store with row/column read/write ports and combinational read).
- Drives the matrix index/orientation/write controls and the select lines of the round datapath (S-box + rotate, MixColumns, AddRoundKey).
- Accepts one plaintext block as 4 column beats, runs ARK0 plus NUM_ROUNDS rounds, then streams 4 ciphertext columns out.
- One block in flight at a time.

Parameters:
- NUM_ROUNDS, 10, total cipher rounds; the last round skips MixColumns. Legal range 2..15.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a block; sampled only in IDLE
- in_valid  in  1  input column beat valid
- in_ready  out  1  high throughout LOAD
- out_valid  out  1  high throughout OUT
- out_ready  in  1  ciphertext consumer ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final output beat
- mat_we  out  1  matrix write enable
- mat_in_idx  out  2  matrix write row/column index
- mat_in_rc  out  1  write orientation: 0 = row, 1 = column
- mat_out_idx  out  2  matrix read row/column index
- mat_out_rc  out  1  read orientation: 0 = row, 1 = column
- dp_sel  out  2  write-data mux: 0 = external column, 1 = sub/shift path, 2 = mix/ark path
- rot_amt  out  2  left byte-rotate amount for the sub/shift path (= row index)
- mix_en  out  1  MixColumns enable on the mix/ark path
- round  out  4  current round number, used for round-key selection
- key_col  out  2  round-key word index (= column index)

Behaviour:
- Reset: state IDLE, all counters 0, every output 0.
- Async reset mid-operation aborts the block; the matrix is not cleared by this block.
- States: IDLE, LOAD, ARK0, SUBSH, MIXARK, OUT. Idx is a 2-bit counter shared by all states and cleared on every state entry.
- IDLE
  - start=1 -> LOAD, round=0.
  - start is ignored in every other state.
- LOAD
  - in_ready=1. A beat is accepted when in_valid & in_ready.
  - On each accepted beat: mat_we=1, mat_in_rc=1, mat_in_idx=idx, dp_sel=0, then idx++.
  - Without in_valid, mat_we=0 and idx holds.
  - Idx=3 beat accepted -> ARK0.
- ARK0 (4 cycles, no stalls)
  - mat_out_rc=mat_in_rc=1, mat_out_idx=mat_in_idx=idx, mat_we=1, dp_sel=2, mix_en=0, round=0, key_col=idx.
  - After idx=3 -> SUBSH, round=1.
- SUBSH (4 cycles)
  - Row read-modify-write: mat_out_rc=mat_in_rc=0, index=idx, rot_amt=idx, dp_sel=1, mat_we=1.
  - After idx=3 -> MIXARK.
- MIXARK (4 cycles)
  - Column read-modify-write: rc=1, index=idx, dp_sel=2, key_col=idx, mat_we=1.
  - mix_en=1 when round<NUM_ROUNDS, else 0.
  - After idx=3: if round==NUM_ROUNDS -> OUT; else round++ and -> SUBSH.
- Read-modify-write: read and write hit the same index in the same cycle. The matrix read is combinational, so the write lands at the clock edge.
- OUT
  - out_valid=1, mat_out_rc=1, mat_out_idx=idx, mat_we=0; the matrix read port carries the ciphertext column.
  - idx++ on each out_valid & out_ready.
  - Idx=3 accepted -> IDLE; done=1 registered in the following cycle, while busy falls.
- Latency (NUM_ROUNDS=10)
  - The first ARK0 cycle is the cycle after the last load beat.
  - out_valid first asserts 84 cycles after that: 4 ARK0 cycles + 10 x 8 round cycles.
- Output stall: the OUT state holds idx and every output unchanged while out_ready=0.
- Unused controls drive 0: mat_we outside write cycles, rot_amt outside SUBSH, mix_en outside MIXARK, key_col outside ARK0/MIXARK.
- round stays constant within a state.

Test Plan:
- Reset: reset_n=0 mid-MIXARK (round=5) -> next cycle all outputs 0 and state IDLE; start then begins a fresh LOAD with in_ready=1.
- Nominal block: start, then 4 back-to-back beats (FIPS-197 plaintext 00112233..ccddeeff with key 000102..0f in the bench datapath).
  - out_valid 84 cycles after ARK0 entry.
  - Columns out 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
  - done a single pulse; busy low the same cycle.
- Input gaps: in_valid toggling 1,0,0,1,1,0,1 -> exactly 4 matrix column writes at idx 0..3, mat_we=0 on gap cycles, and ciphertext identical to the nominal case.
- Control sequence check: monitor asserts the per-round order SUBSH rows 0..3 (rot_amt 0..3), then MIXARK columns 0..3.
  - mix_en=1 for rounds 1..9 and 0 for round 10.
  - round steps 0..10 with no skips.
- Output backpressure: out_ready low for 3 cycles on beat 2 -> mat_out_idx holds at 2 and out_valid stays high; done occurs only after beat 3 is accepted.
- start while busy: start pulses during LOAD, SUBSH and OUT -> ignored, no state change. Back-to-back second block: start asserted in the cycle done pulses -> LOAD entered on the next edge.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the AES round sequencer and
// the block around it (byte-state matrix, round datapath, block I/O).
// master: the sequencer side. slave: the matrix/datapath/host side.
//
// Ports carried:
//   start, in_valid, out_ready        host -> sequencer
//   in_ready, out_valid, busy, done   sequencer -> host
//   mat_we, mat_in_idx, mat_in_rc     matrix write control
//   mat_out_idx, mat_out_rc           matrix read control
//   dp_sel, rot_amt, mix_en           round datapath selects
//   round, key_col                    round-key word selection
interface aes_round_ctrl_if;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       mat_we;
  logic [1:0] mat_in_idx;
  logic       mat_in_rc;
  logic [1:0] mat_out_idx;
  logic       mat_out_rc;
  logic [1:0] dp_sel;
  logic [1:0] rot_amt;
  logic       mix_en;
  logic [3:0] round;
  logic [1:0] key_col;

  modport master (
    input  start,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output busy,
    output done,
    output mat_we,
    output mat_in_idx,
    output mat_in_rc,
    output mat_out_idx,
    output mat_out_rc,
    output dp_sel,
    output rot_amt,
    output mix_en,
    output round,
    output key_col
  );

  modport slave (
    output start,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  busy,
    input  done,
    input  mat_we,
    input  mat_in_idx,
    input  mat_in_rc,
    input  mat_out_idx,
    input  mat_out_rc,
    input  dp_sel,
    input  rot_amt,
    input  mix_en,
    input  round,
    input  key_col
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: loads 4 plaintext columns into the byte-state
// matrix, runs ARK0 plus NUM_ROUNDS rounds as row/column read-modify-write
// passes, then presents the 4 ciphertext columns on the matrix read port.
// Latency: first out_valid 4 + 8*NUM_ROUNDS cycles after the first ARK0 cycle.
// Backpressure: input beats are taken only on in_valid (idx holds on gaps);
// OUT holds idx and every output while out_ready is low.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   bus (master)   start/in_valid/in_ready, out_valid/out_ready, busy, done,
//                  matrix index/orientation/write controls, datapath selects
//                  (dp_sel, rot_amt, mix_en), round and key_col for key lookup.
//
// NUM_ROUNDS must lie in 2..15 (round is a 4-bit count).
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input logic              clk,
  input logic              reset_n,
  aes_round_ctrl_if.master bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  // Write-data mux encodings for dp_sel.
  localparam logic [1:0] DP_EXT   = 2'd0;
  localparam logic [1:0] DP_SUBSH = 2'd1;
  localparam logic [1:0] DP_MIXARK = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARK0   = 3'd2,
    S_SUBSH  = 3'd3,
    S_MIXARK = 3'd4,
    S_OUT    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] round_q, round_d;
  logic       done_q, done_d;

  // Combinational outputs, mirrored onto the interface below.
  logic       in_ready;
  logic       out_valid;
  logic       mat_we;
  logic [1:0] mat_in_idx;
  logic       mat_in_rc;
  logic [1:0] mat_out_idx;
  logic       mat_out_rc;
  logic [1:0] dp_sel;
  logic [1:0] rot_amt;
  logic       mix_en;
  logic [1:0] key_col;

  logic       last_idx;
  logic       in_fire;
  logic       out_fire;

  assign last_idx = (idx_q == 2'd3);
  // Accept conditions use the state directly so they do not loop through
  // the combinational output process.
  assign in_fire  = (state_q == S_LOAD) && bus.in_valid;
  assign out_fire = (state_q == S_OUT) && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      round_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    round_d     = round_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    mat_we      = 1'b0;
    mat_in_idx  = 2'd0;
    mat_in_rc   = 1'b0;
    mat_out_idx = 2'd0;
    mat_out_rc  = 1'b0;
    dp_sel      = DP_EXT;
    rot_amt     = 2'd0;
    mix_en      = 1'b0;
    key_col     = 2'd0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          idx_d   = 2'd0;
          round_d = 4'd0;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_fire) begin
          mat_we     = 1'b1;
          mat_in_rc  = 1'b1;
          mat_in_idx = idx_q;
          dp_sel     = DP_EXT;
          if (last_idx) begin
            state_d = S_ARK0;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      // Initial key whitening: column RMW, no MixColumns, round key 0.
      S_ARK0: begin
        mat_we      = 1'b1;
        mat_in_rc   = 1'b1;
        mat_out_rc  = 1'b1;
        mat_in_idx  = idx_q;
        mat_out_idx = idx_q;
        dp_sel      = DP_MIXARK;
        key_col     = idx_q;
        if (last_idx) begin
          state_d = S_SUBSH;
          idx_d   = 2'd0;
          round_d = 4'd1;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      // SubBytes and ShiftRows fused as a row RMW: row r rotates left by r.
      S_SUBSH: begin
        mat_we      = 1'b1;
        mat_in_rc   = 1'b0;
        mat_out_rc  = 1'b0;
        mat_in_idx  = idx_q;
        mat_out_idx = idx_q;
        dp_sel      = DP_SUBSH;
        rot_amt     = idx_q;
        if (last_idx) begin
          state_d = S_MIXARK;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      // MixColumns and AddRoundKey fused as a column RMW; the final round
      // bypasses MixColumns.
      S_MIXARK: begin
        mat_we      = 1'b1;
        mat_in_rc   = 1'b1;
        mat_out_rc  = 1'b1;
        mat_in_idx  = idx_q;
        mat_out_idx = idx_q;
        dp_sel      = DP_MIXARK;
        key_col     = idx_q;
        mix_en      = (round_q < LAST_ROUND);
        if (last_idx) begin
          idx_d = 2'd0;
          if (round_q == LAST_ROUND) begin
            state_d = S_OUT;
          end else begin
            state_d = S_SUBSH;
            round_d = round_q + 4'd1;
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      // Ciphertext columns come straight off the matrix read port.
      S_OUT: begin
        out_valid   = 1'b1;
        mat_out_rc  = 1'b1;
        mat_out_idx = idx_q;
        if (out_fire) begin
          if (last_idx) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            round_d = 4'd0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
        round_d = 4'd0;
      end
    endcase
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.mat_we      = mat_we;
  assign bus.mat_in_idx  = mat_in_idx;
  assign bus.mat_in_rc   = mat_in_rc;
  assign bus.mat_out_idx = mat_out_idx;
  assign bus.mat_out_rc  = mat_out_rc;
  assign bus.dp_sel      = dp_sel;
  assign bus.rot_amt     = rot_amt;
  assign bus.mix_en      = mix_en;
  assign bus.round       = round_q;
  assign bus.key_col     = key_col;

endmodule
